lc3b_mem_if: RTL and testbench
==============================

Name: lc3b_mem_if

Overview:
- Memory-side counterpart of the datapath register file. The register file sinks BUS; this block sources BUS (GateMDR) and initiates memory cycles.
- Holds MAR and MDR and runs the LC-3b memory handshake toward an external memory with variable latency.
- Returns the ready flag R to the control store and handles word and byte accesses, including byte-lane steering and sign extension.
- Sits between the datapath BUS and the memory port. The top level owns the tristate: BUS = BUS_DRV ? BUS_OUT : 16'hzzzz.

Parameters:
- ACK_TIMEOUT, 255, max cycles waiting for mem_ack before abort; 0 disables the timeout.
- CNT_W, 8, timeout counter width; ACK_TIMEOUT must be < 2^CNT_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- LD_MAR  in  1  load MAR from BUS_IN
- LD_MDR  in  1  load MDR (source selected by MIO_EN)
- GATE_MDR  in  1  drive MDR onto BUS
- MIO_EN  in  1  memory access request from control
- R_W  in  1  1 = write, 0 = read
- DATA_SIZE  in  1  1 = word, 0 = byte
- BUS_IN  in  16  current BUS value
- BUS_OUT  out  16  MDR bus value
- BUS_DRV  out  1  equals GATE_MDR
- R  out  1  ready, one-cycle pulse
- ERR  out  1  timeout, one-cycle pulse concurrent with R
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  16  word-aligned address
- mem_be  out  2  byte enables, [1] = high byte
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data, valid with mem_ack
- mem_ack  in  1  memory completion

Behaviour:
- Reset values: MAR, MDR, RDATA = 0; state = IDLE; all outputs 0 (BUS_OUT = 0).
- MAR
  - LD_MAR: MAR <= BUS_IN on the next edge.
  - LD_MAR is ignored while state != IDLE.
- MDR
  - LD_MDR && !MIO_EN: MDR <= DATA_SIZE ? BUS_IN : {BUS_IN[7:0], BUS_IN[7:0]}.
  - LD_MDR && MIO_EN && R: MDR <= RDATA.
  - LD_MDR && MIO_EN && !R: no load.
- BUS_OUT
  - Word: BUS_OUT = MDR.
  - Byte: BUS_OUT = sign-extended MAR[0] ? MDR[15:8] : MDR[7:0].
  - Combinational.
- FSM states: IDLE, ACCESS, DONE.
- IDLE -> ACCESS when MIO_EN = 1. Latch on that edge:
  - mem_addr = {MAR[15:1], 0}
  - mem_we = R_W
  - mem_be = DATA_SIZE ? 11 : (MAR[0] ? 10 : 01)
  - mem_wdata = MDR
- ACCESS
  - mem_req = 1; all request fields are held stable.
  - mem_ack: RDATA <= mem_rdata, then go to DONE.
  - Timeout counter increments each ACCESS cycle. At count == ACK_TIMEOUT with no ack: go to DONE, set ERR, RDATA <= 16'h0000.
- DONE
  - R = 1 and mem_req = 0 for exactly 1 cycle, then IDLE.
  - ERR is high in the same cycle only on timeout.
- Latency: MIO_EN rises in cycle 0, mem_req is high from cycle 1, ack arrives in cycle k, R is high in cycle k+1. Minimum R latency is 2 cycles (ack in cycle 1).
- Back-to-back: if MIO_EN is still high in the IDLE cycle after DONE, a new access starts. Control must drop MIO_EN in the cycle after R.
- MIO_EN dropping during ACCESS does not cancel the access. It completes and R still pulses.
- Misaligned word access (MAR[0] = 1, DATA_SIZE = 1): address is forced even, be = 11, no error.
- mem_ack in IDLE or DONE is ignored.
- mem_ack in the same cycle as the timeout: the ack wins and ERR = 0.
- rst mid-access: IDLE on the next edge, mem_req = 0, no R pulse, all registers cleared.
- Write byte: mem_wdata carries the replicated byte in MDR; mem_be selects the lane.

Test Plan:
- Word read: BUS_IN = 16'h3000 with LD_MAR; MIO_EN = 1, R_W = 0, DATA_SIZE = 1; memory acks after 3 cycles with 16'hBEEF.
  - mem_addr = 16'h3000, mem_be = 11.
  - R pulses 1 cycle after ack.
  - LD_MDR during R, then GATE_MDR -> BUS_OUT = 16'hBEEF, BUS_DRV = 1.
- Byte read, odd address: MAR = 16'h3001, mem_rdata = 16'h80FF.
  - mem_addr = 16'h3000, mem_be = 10.
  - BUS_OUT = 16'hFF80.
  - Same data with MAR = 16'h3000 -> BUS_OUT = 16'hFFFF.
- Byte write: BUS_IN = 16'h1234 with LD_MDR, DATA_SIZE = 0, MAR = 16'h4001, R_W = 1.
  - mem_wdata = 16'h3434, mem_be = 10, mem_we = 1.
  - Minimum-latency ack (cycle 1) -> R in cycle 2.
- Timeout: ACK_TIMEOUT = 4, mem_ack is never asserted.
  - mem_req is high 4 cycles, then R = ERR = 1 for 1 cycle.
  - MDR loads 0.
- Reset mid-access: rst during ACCESS.
  - Next cycle: mem_req = 0, MAR = MDR = 0.
  - A later mem_ack produces no R.
- MIO_EN dropped after 1 cycle of ACCESS: request is held until ack; R still pulses once.

Source files
------------

// File: rtl/lc3b_mem_if.sv
// LC-3b memory interface: owns MAR/MDR, sources BUS through GateMDR and runs the
// variable-latency request/ack handshake, returning a one-cycle ready pulse R.
module lc3b_mem_if #(
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        GATE_MDR,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic        DATA_SIZE,
    input  logic [15:0] BUS_IN,
    output logic [15:0] BUS_OUT,
    output logic        BUS_DRV,
    output logic        R,
    output logic        ERR,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Last ACCESS cycle index before giving up; only meaningful when the timeout is enabled.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam bit               TIMEOUT_EN   = (ACK_TIMEOUT != 0);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              err_reg, err_next;
    logic [15:0]       mar_reg, mar_next;
    logic [15:0]       mdr_reg, mdr_next;
    logic [15:0]       rdata_reg, rdata_next;
    logic [15:0]       addr_reg, addr_next;
    logic [1:0]        be_reg, be_next;
    logic              we_reg, we_next;
    logic [15:0]       wdata_reg, wdata_next;

    logic              start;
    logic              timeout_hit;
    logic [1:0]        lane_be;
    logic [7:0]        byte_sel;

    assign start       = (state_reg == IDLE) && MIO_EN;
    assign timeout_hit = TIMEOUT_EN && (cnt_reg == TIMEOUT_LAST);

    // Lane 1 is the high byte; a word access enables both lanes regardless of MAR[0].
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            if (gi == 1) begin : g_hi
                assign lane_be[gi] = DATA_SIZE | mar_reg[0];
            end else begin : g_lo
                assign lane_be[gi] = DATA_SIZE | ~mar_reg[0];
            end
        end
    endgenerate

    // Control FSM and handshake bookkeeping.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        rdata_next = rdata_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                err_next = 1'b0;
                if (MIO_EN) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_next = DONE;
                    err_next   = 1'b0;
                    rdata_next = mem_rdata;
                end else if (timeout_hit) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                    rdata_next = 16'h0000;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // MAR/MDR loads and the request fields captured when an access starts.
    always_comb begin
        mar_next   = mar_reg;
        mdr_next   = mdr_reg;
        addr_next  = addr_reg;
        be_next    = be_reg;
        we_next    = we_reg;
        wdata_next = wdata_reg;

        if (LD_MAR && (state_reg == IDLE)) begin
            mar_next = BUS_IN;
        end

        if (LD_MDR) begin
            if (!MIO_EN) begin
                mdr_next = DATA_SIZE ? BUS_IN : {BUS_IN[7:0], BUS_IN[7:0]};
            end else if (state_reg == DONE) begin
                mdr_next = rdata_reg;
            end
        end

        if (start) begin
            addr_next  = {mar_reg[15:1], 1'b0};
            be_next    = lane_be;
            we_next    = R_W;
            wdata_next = mdr_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            mar_reg   <= 16'h0000;
            mdr_reg   <= 16'h0000;
            rdata_reg <= 16'h0000;
            addr_reg  <= 16'h0000;
            be_reg    <= 2'b00;
            we_reg    <= 1'b0;
            wdata_reg <= 16'h0000;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            mar_reg   <= mar_next;
            mdr_reg   <= mdr_next;
            rdata_reg <= rdata_next;
            addr_reg  <= addr_next;
            be_reg    <= be_next;
            we_reg    <= we_next;
            wdata_reg <= wdata_next;
        end
    end

    // Byte reads pick the lane addressed by MAR[0] and sign-extend it onto BUS.
    assign byte_sel = mar_reg[0] ? mdr_reg[15:8] : mdr_reg[7:0];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_bus
            if (gi < 8) begin : g_low
                assign BUS_OUT[gi] = DATA_SIZE ? mdr_reg[gi] : byte_sel[gi];
            end else begin : g_ext
                assign BUS_OUT[gi] = DATA_SIZE ? mdr_reg[gi] : byte_sel[7];
            end
        end
    endgenerate

    assign BUS_DRV   = GATE_MDR;
    assign R         = (state_reg == DONE);
    assign ERR       = (state_reg == DONE) && err_reg;
    assign mem_req   = (state_reg == ACCESS);
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_be    = be_reg;
    assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_lc3b_mem_if.sv
// Testbench for lc3b_mem_if: table-driven accesses with a request/response
// scoreboard, plus hand-written reset and idle-ack sequences.
module tb_lc3b_mem_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        LD_MAR, LD_MDR, GATE_MDR, MIO_EN, R_W, DATA_SIZE;
    logic [15:0] BUS_IN;
    logic [15:0] BUS_OUT;
    logic        BUS_DRV, R, ERR;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_be;

    int tests = 0;
    int fails = 0;

    lc3b_mem_if #(.ACK_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .GATE_MDR(GATE_MDR),
        .MIO_EN(MIO_EN), .R_W(R_W), .DATA_SIZE(DATA_SIZE),
        .BUS_IN(BUS_IN), .BUS_OUT(BUS_OUT), .BUS_DRV(BUS_DRV),
        .R(R), .ERR(ERR),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [1:0]  be;
        logic        we;
        logic [15:0] wdata;
    } req_t;

    typedef struct {
        logic [15:0] mar;
        logic        ds;
        logic        rw;
        logic [15:0] wbus;
        int          ack_cyc;   // ACCESS cycle carrying mem_ack, 0 = never
        logic [15:0] rdata;
        logic        ld_rd;     // LD_MDR during R
        logic        drop_mio;  // drop MIO_EN after one ACCESS cycle
        logic [15:0] e_addr;
        logic [1:0]  e_be;
        logic        e_we;
        logic [15:0] e_wdata;
        logic        e_err;
        int          e_lat;
        int          e_req;
        logic [15:0] e_bus;
    } vec_t;

    req_t req_q[$];
    logic rsp_q[$];
    req_t cur_req;
    bit   cur_valid = 0;
    bit   req_prev  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: request fields on every mem_req cycle, ERR on every R pulse.
    always @(negedge clk) begin
        if (mem_req && !req_prev) begin
            check("req_expected", 32'(req_q.size() != 0), 1);
            cur_valid = (req_q.size() != 0);
            if (cur_valid) cur_req = req_q.pop_front();
        end
        if (mem_req && cur_valid) begin
            check("mem_addr", mem_addr, cur_req.addr);
            check("mem_be", mem_be, cur_req.be);
            check("mem_we", mem_we, cur_req.we);
            check("mem_wdata", mem_wdata, cur_req.wdata);
        end
        if (R) begin
            check("r_expected", 32'(rsp_q.size() != 0), 1);
            if (rsp_q.size() != 0) check("err", ERR, rsp_q.pop_front());
        end else begin
            check("err_without_r", ERR, 0);
        end
        req_prev = mem_req;
    end

    task automatic run_vec(input int idx, input vec_t v);
        int c;
        bit seen;
        int req_cyc;
        @(negedge clk);
        BUS_IN = v.mar; LD_MAR = 1'b1;
        if (v.rw) begin
            @(negedge clk);
            LD_MAR = 1'b0; BUS_IN = v.wbus; LD_MDR = 1'b1; DATA_SIZE = v.ds;
        end
        @(negedge clk);
        LD_MAR = 1'b0; LD_MDR = 1'b0; MIO_EN = 1'b1; R_W = v.rw; DATA_SIZE = v.ds;
        req_q.push_back('{v.e_addr, v.e_be, v.e_we, v.e_wdata});
        rsp_q.push_back(v.e_err);
        c = 0; seen = 0; req_cyc = 0;
        while (!seen && c < 12) begin
            @(negedge clk);
            c++;
            // MAR must not move while an access is in flight.
            LD_MAR = 1'b1; BUS_IN = ~v.mar;
            if (v.drop_mio && c == 2) MIO_EN = 1'b0;
            mem_ack   = (c == v.ack_cyc);
            mem_rdata = (c == v.ack_cyc) ? v.rdata : 16'hDEAD;
            #1;
            if (mem_req) req_cyc++;
            if (R) begin
                seen = 1;
                if (v.ld_rd) LD_MDR = 1'b1;
            end
        end
        check("r_seen", 32'(seen), 1);
        check("latency", c, v.e_lat);
        check("req_cycles", req_cyc, v.e_req);
        @(negedge clk);
        MIO_EN = 1'b0; LD_MDR = 1'b0; LD_MAR = 1'b0; mem_ack = 1'b0;
        GATE_MDR = 1'b1; DATA_SIZE = v.ds;
        #1;
        check("bus_out", BUS_OUT, v.e_bus);
        check("bus_drv", BUS_DRV, 1);
        check("r_single", R, 0);
        $display("[TB] vec %0d mar=%h ds=%0d rw=%0d addr=%h be=%b lat=%0d req=%0d bus=%h",
                 idx, v.mar, v.ds, v.rw, v.e_addr, v.e_be, c, req_cyc, BUS_OUT);
        @(negedge clk);
        GATE_MDR = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        // mar, ds, rw, wbus, ack, rdata, ld_rd, drop | addr, be, we, wdata, err, lat, req, bus
        vecs[0] = '{16'h3000, 1, 0, 16'h0000, 3, 16'hBEEF, 1, 0, 16'h3000, 2'b11, 0, 16'h0000, 0, 4, 3, 16'hBEEF};
        vecs[1] = '{16'h3001, 0, 0, 16'h0000, 2, 16'h80FF, 1, 0, 16'h3000, 2'b10, 0, 16'hBEEF, 0, 3, 2, 16'hFF80};
        vecs[2] = '{16'h3000, 0, 0, 16'h0000, 1, 16'h80FF, 1, 0, 16'h3000, 2'b01, 0, 16'h80FF, 0, 2, 1, 16'hFFFF};
        vecs[3] = '{16'h4001, 0, 1, 16'h1234, 1, 16'h5555, 0, 0, 16'h4000, 2'b10, 1, 16'h3434, 0, 2, 1, 16'h0034};
        vecs[4] = '{16'h5000, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h5000, 2'b11, 0, 16'h3434, 1, 5, 4, 16'h0000};
        vecs[5] = '{16'h6003, 1, 0, 16'h0000, 2, 16'h7F01, 1, 0, 16'h6002, 2'b11, 0, 16'h0000, 0, 3, 2, 16'h7F01};
        vecs[6] = '{16'h6002, 0, 0, 16'h0000, 1, 16'h7F01, 1, 0, 16'h6002, 2'b01, 0, 16'h7F01, 0, 2, 1, 16'h0001};
        vecs[7] = '{16'h7000, 1, 1, 16'hA5C3, 3, 16'h0000, 0, 0, 16'h7000, 2'b11, 1, 16'hA5C3, 0, 4, 3, 16'hA5C3};
        vecs[8] = '{16'h8000, 1, 0, 16'h0000, 4, 16'h1357, 1, 0, 16'h8000, 2'b11, 0, 16'hA5C3, 0, 5, 4, 16'h1357};
        vecs[9] = '{16'hA000, 1, 0, 16'h0000, 3, 16'h2468, 0, 1, 16'hA000, 2'b11, 0, 16'h1357, 0, 4, 3, 16'h1357};

        rst = 1'b1; LD_MAR = 0; LD_MDR = 0; GATE_MDR = 0; MIO_EN = 0; R_W = 0; DATA_SIZE = 0;
        BUS_IN = 16'h0000; mem_rdata = 16'h0000; mem_ack = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_bus_out", BUS_OUT, 16'h0000);
        check("rst_bus_drv", BUS_DRV, 0);
        check("rst_r", R, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_be", mem_be, 2'b00);
        check("rst_mem_wdata", mem_wdata, 16'h0000);
        $display("[TB] reset state checked");

        // Ack while idle must be ignored.
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        @(negedge clk); mem_ack = 1'b0; #1;
        check("idle_ack_r", R, 0);
        check("idle_ack_req", mem_req, 0);
        $display("[TB] idle ack ignored");

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Reset in the middle of an access.
        @(negedge clk); BUS_IN = 16'h9001; LD_MAR = 1'b1;
        @(negedge clk); LD_MAR = 1'b0; BUS_IN = 16'hABCD; LD_MDR = 1'b1; DATA_SIZE = 1'b1;
        @(negedge clk); LD_MDR = 1'b0; MIO_EN = 1'b1; R_W = 1'b0;
        req_q.push_back('{16'h9000, 2'b11, 1'b0, 16'hABCD});
        @(negedge clk); #1;
        check("mid_req_high", mem_req, 1);
        @(negedge clk); MIO_EN = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0; GATE_MDR = 1'b1; DATA_SIZE = 1'b1; #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_r", R, 0);
        check("mid_rst_mdr", BUS_OUT, 16'h0000);
        check("mid_rst_addr", mem_addr, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'hFFFF; #1;
            check("late_ack_r", R, 0);
        end
        @(negedge clk); mem_ack = 1'b0; #1;
        check("late_ack_r2", R, 0);
        // A fresh byte write without reloading MAR/MDR exposes their cleared values.
        @(negedge clk); GATE_MDR = 1'b0; MIO_EN = 1'b1; DATA_SIZE = 1'b0; R_W = 1'b1;
        req_q.push_back('{16'h0000, 2'b01, 1'b1, 16'h0000});
        rsp_q.push_back(1'b0);
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'h0000;
        @(negedge clk); mem_ack = 1'b0; MIO_EN = 1'b0; #1;
        check("post_rst_r", R, 1);
        $display("[TB] reset mid-access sequence done");

        repeat (3) @(negedge clk);
        check("req_q_drained", req_q.size(), 0);
        check("rsp_q_drained", rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
